muldiv_sequencer: RTL
=====================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; the iteration count equals DATA_W.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start_mult  input  1  request a signed multiply of op_a by op_b.
REQ-005 SHALL have port start_div  input  1  request a signed divide of op_a by op_b.
REQ-006 SHALL have port op_a  input  DATA_W  multiplicand or dividend (two's complement).
REQ-007 SHALL have port op_b  input  DATA_W  multiplier or divisor (two's complement).
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; hi and lo are valid in that cycle.
REQ-010 SHALL have port div0  output  1  one-cycle pulse on a divide with op_b equal to 0.
REQ-011 SHALL have port hi  output  DATA_W  multiply upper half, or divide remainder.
REQ-012 SHALL have port lo  output  DATA_W  multiply lower half, or divide quotient.

Function
REQ-013 SHALL implement the FSM states IDLE, MULT, DIV, DIV_FIX and DONE.
REQ-014 SHALL, in IDLE, sample start_mult, start_div, op_a and op_b at each clock edge; op_a and op_b are latched internally, so later changes have no effect.
REQ-015 SHALL give start_mult priority when start_mult and start_div are both high.
REQ-016 SHALL ignore starts received in any state other than IDLE.
REQ-017 SHALL, for a start accepted at edge t:
  - assert busy from cycle t+1 until done;
  - run exactly DATA_W iteration cycles in MULT or DIV, with a counter running 0..DATA_W-1.
REQ-018 SHALL compute multiply as signed DATA_W x DATA_W to a 2*DATA_W product using iterative Booth radix-2.
  - hi = product[2*DATA_W-1:DATA_W], lo = product[DATA_W-1:0].
  - done asserts in cycle t+DATA_W+1.
REQ-019 SHALL compute divide as restoring division on magnitudes, followed by one DIV_FIX cycle for sign correction.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - done asserts in cycle t+DATA_W+2.
REQ-020 SHALL return lo = 0x80000000 and hi = 0 for -2^(DATA_W-1) / -1 (wrap), with no flag.
REQ-021 SHALL handle start_div with op_b == 0 as follows:
  - no iteration is performed;
  - div0 pulses in cycle t+1;
  - busy and done stay low, and hi and lo keep their prior values.
REQ-022 SHALL update hi and lo only on the edge that enters DONE; they hold between operations.
REQ-023 SHALL leave DONE for IDLE after one cycle; a start may be accepted on the edge ending DONE's successor IDLE cycle, giving a minimum of one idle cycle between operations.
REQ-024 SHALL keep done and div0 mutually exclusive and never high for more than one cycle.

Reset
REQ-025 SHALL, on reset assertion and without waiting for clk:
  - force the state to IDLE;
  - force the counter and all internal operand and accumulator registers to 0;
  - force busy, done, div0, hi and lo to 0.
REQ-026 SHALL abort any operation in progress when reset asserts mid-operation, with no done or div0 generated for it.
REQ-027 SHALL ignore starts while reset is high; the first start is accepted on the first clock edge after reset deasserts.

Structure
REQ-028 SHALL place the FSM state type, DATA_W default and iteration-count constant in the shared CPU package.
REQ-029 SHALL keep the per-iteration restoring subtract/compare stage as one combinational sub-module, div_step.
  - The Booth add/shift step, counter and FSM stay in muldiv_sequencer.
REQ-030 SHALL NOT instantiate any other sub-modules.

Verification
REQ-031 SHALL cover: mult 7 x -3 (0x00000007, 0xFFFFFFFD) -> done at t+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-032 SHALL cover: mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-033 SHALL cover: div -7 / 2 -> done at t+34, lo=0xFFFFFFFD, hi=0xFFFFFFFF; and div 7 / -2 -> lo=0xFFFFFFFD, hi=0x00000001.
REQ-034 SHALL cover: div 5 / 0 after a prior result -> div0 high only in cycle t+1, busy=0, done never asserted, hi and lo unchanged.
REQ-035 SHALL cover: div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; then simultaneous start_mult and start_div -> multiply executes.
REQ-036 SHALL cover: reset pulse at iteration 10 of a multiply -> immediate busy=0, hi=lo=0, no done; then 3 x 4 -> lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package muldiv_sequencer_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ITER_COUNT     = DATA_W_DEFAULT;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MULT    = 3'd1,
        DIV     = 3'd2,
        DIV_FIX = 3'd3,
        DONE    = 3'd4
    } muldivState_t;

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference if it fits.
module div_step
    import muldiv_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] remIn,
    input  logic [DATA_W-1:0] quoIn,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] remOut,
    output logic [DATA_W-1:0] quoOut
);

    logic [DATA_W:0] shifted_s;
    logic [DATA_W:0] diff_s;

    assign shifted_s = {remIn, quoIn[DATA_W-1]};
    assign diff_s    = shifted_s - {1'b0, divisor};

    // Trial subtract and restore
    always_comb begin
        remOut = shifted_s[DATA_W-1:0];
        quoOut = {quoIn[DATA_W-2:0], 1'b0};
        if (shifted_s >= {1'b0, divisor}) begin
            remOut = diff_s[DATA_W-1:0];
            quoOut = {quoIn[DATA_W-2:0], 1'b1};
        end else begin
            remOut = shifted_s[DATA_W-1:0];
            quoOut = {quoIn[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequential signed multiplier (Booth radix-2) and divider (restoring on
// magnitudes plus a sign-fix cycle) sharing one control FSM.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic              div0,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    muldivState_t      state_r;
    logic [CNT_W-1:0]  count_r;
    logic              busy_r, done_r, div0_r;
    logic [DATA_W-1:0] hi_r, lo_r;

    // Booth accumulator carries one extra bit so A - M cannot overflow for M = -2^(W-1)
    logic [DATA_W:0]   boothAcc_r, boothM_r;
    logic [DATA_W-1:0] boothQ_r;
    logic              boothQm1_r;
    logic [DATA_W:0]   boothSum_s, boothAccNext_s;
    logic [DATA_W-1:0] boothQNext_s;

    logic [DATA_W-1:0] divRem_r, divQuo_r, divDen_r;
    logic              negQuo_r, negRem_r;
    logic [DATA_W-1:0] divRemNext_s, divQuoNext_s;
    logic [DATA_W-1:0] absA_s, absB_s;

    assign absA_s = op_a[DATA_W-1] ? -op_a : op_a;
    assign absB_s = op_b[DATA_W-1] ? -op_b : op_b;

    // Booth recode of the current multiplier bit pair
    always_comb begin
        boothSum_s = boothAcc_r;
        case ({boothQ_r[0], boothQm1_r})
            2'b01:   boothSum_s = boothAcc_r + boothM_r;
            2'b10:   boothSum_s = boothAcc_r - boothM_r;
            default: boothSum_s = boothAcc_r;
        endcase
    end

    assign boothAccNext_s = {boothSum_s[DATA_W], boothSum_s[DATA_W:1]};
    assign boothQNext_s   = {boothSum_s[0], boothQ_r[DATA_W-1:1]};

    div_step #(.DATA_W(DATA_W)) u_divStep (
        .remIn   (divRem_r),
        .quoIn   (divQuo_r),
        .divisor (divDen_r),
        .remOut  (divRemNext_s),
        .quoOut  (divQuoNext_s)
    );

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            count_r    <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div0_r     <= 1'b0;
            hi_r       <= {DATA_W{1'b0}};
            lo_r       <= {DATA_W{1'b0}};
            boothAcc_r <= {(DATA_W+1){1'b0}};
            boothM_r   <= {(DATA_W+1){1'b0}};
            boothQ_r   <= {DATA_W{1'b0}};
            boothQm1_r <= 1'b0;
            divRem_r   <= {DATA_W{1'b0}};
            divQuo_r   <= {DATA_W{1'b0}};
            divDen_r   <= {DATA_W{1'b0}};
            negQuo_r   <= 1'b0;
            negRem_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            div0_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    count_r <= {CNT_W{1'b0}};
                    if (start_mult) begin
                        boothAcc_r <= {(DATA_W+1){1'b0}};
                        boothM_r   <= {op_a[DATA_W-1], op_a};
                        boothQ_r   <= op_b;
                        boothQm1_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= MULT;
                    end else if (start_div) begin
                        if (op_b == {DATA_W{1'b0}}) begin
                            div0_r <= 1'b1;
                        end else begin
                            divRem_r <= {DATA_W{1'b0}};
                            divQuo_r <= absA_s;
                            divDen_r <= absB_s;
                            negQuo_r <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
                            negRem_r <= op_a[DATA_W-1];
                            busy_r   <= 1'b1;
                            state_r  <= DIV;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                MULT: begin
                    boothAcc_r <= boothAccNext_s;
                    boothQ_r   <= boothQNext_s;
                    boothQm1_r <= boothQ_r[0];
                    count_r    <= count_r + CNT_W'(1);
                    if (count_r == LAST_CNT) begin
                        hi_r    <= boothAccNext_s[DATA_W-1:0];
                        lo_r    <= boothQNext_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= MULT;
                    end
                end
                DIV: begin
                    divRem_r <= divRemNext_s;
                    divQuo_r <= divQuoNext_s;
                    count_r  <= count_r + CNT_W'(1);
                    if (count_r == LAST_CNT) begin
                        state_r <= DIV_FIX;
                    end else begin
                        state_r <= DIV;
                    end
                end
                DIV_FIX: begin
                    hi_r    <= negRem_r ? -divRem_r : divRem_r;
                    lo_r    <= negQuo_r ? -divQuo_r : divQuo_r;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign div0 = div0_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
